oc_wired_and_arbiter: RTL and testbench

//  Parametrised successor to the 3-input open-collector gates: N_CH channels share one modelled

---
 rtl/oc_wired_and_arbiter_pkg.sv | 18 +
 rtl/oc_wired_and_arbiter_if.sv | 26 ++
 rtl/oc_wired_and_arbiter_line.sv | 10 +
 rtl/oc_wired_and_arbiter.sv | 93 +++++++++
 tb/tb_oc_wired_and_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/oc_wired_and_arbiter_pkg.sv
// Shared types and helpers for the open-collector bit-serial arbiter.
// The lowest-set-bit helper works on a fixed-width vector so it can be used for any channel count.
package oc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int MAX_CH = 64;

  // Two's-complement trick: v & -v isolates the lowest set bit.
  function automatic logic [MAX_CH-1:0] lowest_onehot(input logic [MAX_CH-1:0] v);
    return v & (~v + MAX_CH'(1));
  endfunction

endpackage

// File: rtl/oc_wired_and_arbiter_if.sv
// Request/result bundle of the wired-AND arbiter.
// The master side issues rounds; the slave side is the arbiter.
interface oc_wired_and_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int WORD_W = 8
);
  logic                   start;
  logic [N_CH-1:0]        req;
  logic [N_CH*WORD_W-1:0] word;
  logic                   busy;
  logic                   line_o;
  logic [N_CH-1:0]        alive;
  logic [N_CH-1:0]        grant;
  logic [WORD_W-1:0]      win_word;
  logic                   done;

  modport master (
    output start, req, word,
    input  busy, line_o, alive, grant, win_word, done
  );

  modport slave (
    input  start, req, word,
    output busy, line_o, alive, grant, win_word, done
  );
endinterface

// File: rtl/oc_wired_and_arbiter_line.sv
// Open-collector line model: any enabled driver sending 0 pulls the shared line low.
module oc_wired_and #(
  parameter int N = 3
) (
  input  logic [N-1:0] drive,
  input  logic [N-1:0] en,
  output logic         line
);
  assign line = &(drive | ~en);
endmodule

// File: rtl/oc_wired_and_arbiter.sv
// Bit-serial arbiter over a shared wired-AND line, MSB first; lowest word wins,
// ties resolved toward the lowest channel index.
module oc_wired_and_arbiter
  import oc_arb_pkg::*;
#(
  parameter  int N_CH   = 3,
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oc_wired_and_arbiter_if.slave bus
);

  arb_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [N_CH-1:0]   alive_reg;
  logic [N_CH-1:0]   msb;
  logic [WORD_W-1:0] win_word_reg;
  logic              line_reg;
  logic              line;
  logic              load;
  logic              last_bit;
  logic [MAX_CH-1:0] grant_wide;
  logic              unused_grant_hi;

  assign load     = (state_reg == IDLE) && bus.start && (|bus.req);
  assign last_bit = (bit_cnt_reg == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (load) state_next = ARB;
      ARB:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each channel shifts its latched word out MSB first while the round runs.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [WORD_W-1:0] sh_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 sh_reg <= '0;
      else if (load)              sh_reg <= bus.word[gi*WORD_W +: WORD_W];
      else if (state_reg == ARB)  sh_reg <= sh_reg << 1;
    end

    assign msb[gi] = sh_reg[WORD_W-1];
  end

  // Dropped-out channels are disabled, which is the same as releasing the line.
  oc_wired_and #(.N(N_CH)) u_line (
    .drive (msb),
    .en    (alive_reg),
    .line  (line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_reg    <= '0;
      bit_cnt_reg  <= '0;
      win_word_reg <= '0;
      line_reg     <= 1'b0;
    end else if (load) begin
      alive_reg   <= bus.req;
      bit_cnt_reg <= '0;
    end else if (state_reg == ARB) begin
      // A channel that released the line but sees it low has lost.
      alive_reg    <= alive_reg & ~(msb & {N_CH{~line}});
      win_word_reg <= (win_word_reg << 1) | WORD_W'(line);
      line_reg     <= line;
      bit_cnt_reg  <= bit_cnt_reg + 1'b1;
    end
  end

  assign grant_wide      = lowest_onehot(MAX_CH'(alive_reg));
  assign unused_grant_hi = ^grant_wide[MAX_CH-1:N_CH];

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.grant    = (state_reg == DONE) ? grant_wide[N_CH-1:0] : '0;
  assign bus.alive    = alive_reg;
  assign bus.win_word = win_word_reg;
  assign bus.line_o   = line_reg;

endmodule

// File: tb/tb_oc_wired_and_arbiter.sv
// Randomised scoreboard bench for the wired-AND arbiter; the reference picks the
// numerically smallest requesting word directly instead of simulating the line.
module tb_oc_wired_and_arbiter;
  import oc_arb_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] alive;
    logic [W-1:0] win;
    logic         line;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oc_wired_and_arbiter_if #(.N_CH(N), .WORD_W(W)) bus ();

  oc_wired_and_arbiter #(.N_CH(N), .WORD_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t last_exp;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic exp_t model(input logic [N-1:0] r, input logic [N*W-1:0] w);
    exp_t e;
    int   best;
    e    = '0;
    best = -1;
    for (int k = 0; k < N; k++)
      if (r[k] && (best < 0 || w[k*W +: W] < w[best*W +: W])) best = k;
    if (best >= 0) begin
      e.grant[best] = 1'b1;
      e.win         = w[best*W +: W];
      e.line        = e.win[0];
      for (int k = 0; k < N; k++)
        e.alive[k] = r[k] && (w[k*W +: W] == e.win);
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_grant",    32'(bus.grant),    32'(e.grant));
          check("sb_alive",    32'(bus.alive),    32'(e.alive));
          check("sb_win_word", 32'(bus.win_word), 32'(e.win));
          check("sb_line_o",   32'(bus.line_o),   32'(e.line));
          $display("round done: grant=%b alive=%b win_word=%h", bus.grant, bus.alive, bus.win_word);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_grant"},    32'(bus.grant),    32'd0);
    check({tag, "_alive"},    32'(bus.alive),    32'd0);
    check({tag, "_win_word"}, 32'(bus.win_word), 32'd0);
    check({tag, "_line_o"},   32'(bus.line_o),   32'd0);
  endtask

  task automatic run_round(input logic [N-1:0] r, input logic [N*W-1:0] w,
                           input bit disturb, input bit do_reset);
    exp_t e;
    int   n;
    e = model(r, w);
    @(negedge clk);
    bus.start = 1'b1;
    bus.req   = r;
    bus.word  = w;
    if (!do_reset) exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    if (do_reset) begin
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      check("mid_reset_no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = '0;
      $display("round aborted by reset: req=%b word=%h", r, w);
      return;
    end
    while (bus.done !== 1'b1 && n < W + 4) begin
      if (disturb && n == 3) begin
        bus.start = 1'b1;
        bus.req   = N'($urandom);
        bus.word  = (N*W)'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("done_in_window", 32'(bus.done === 1'b1 && n >= W && n <= W + 1), 32'd1);
    @(negedge clk);
    check("post_done",  32'(bus.done),  32'd0);
    check("post_grant", 32'(bus.grant), 32'd0);
    check("post_busy",  32'(bus.busy),  32'd0);
    check("hold_alive", 32'(bus.alive), 32'(e.alive));
    check("hold_win",   32'(bus.win_word), 32'(e.win));
    last_exp = e;
    bus.word = (N*W)'($urandom);
  endtask

  task automatic idle_start_zero();
    @(negedge clk);
    bus.start = 1'b1;
    bus.req   = '0;
    bus.word  = (N*W)'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      check("zero_req_busy", 32'(bus.busy), 32'd0);
      check("zero_req_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    check("zero_req_alive", 32'(bus.alive),    32'(last_exp.alive));
    check("zero_req_win",   32'(bus.win_word), 32'(last_exp.win));
    check("zero_req_line",  32'(bus.line_o),   32'(last_exp.line));
    $display("start with req=0 ignored");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] w;
    logic [W-1:0]   pool [3];
    bus.start = 1'b0;
    bus.req   = '0;
    bus.word  = '0;
    last_exp  = '0;
    pool[0] = 8'h10; pool[1] = 8'h11; pool[2] = 8'h90;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_round(3'b111, {8'h7F, 8'h3C, 8'h5A}, 1'b0, 1'b0);
    run_round(3'b111, {8'h80, 8'h10, 8'h10}, 1'b0, 1'b0);
    run_round(3'b100, {8'hFF, 8'h00, 8'h00}, 1'b0, 1'b0);
    idle_start_zero();
    run_round(3'b111, {8'h7F, 8'h3C, 8'h5A}, 1'b0, 1'b1);
    run_round(3'b111, {8'h7F, 8'h3C, 8'h5A}, 1'b0, 1'b0);
    run_round(3'b111, {8'h7F, 8'h3C, 8'h5A}, 1'b1, 1'b0);
    run_round(3'b111, {8'hFF, 8'hFF, 8'hFF}, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    w[k*W +: W] = W'($urandom);
          2:       w[k*W +: W] = pool[$urandom_range(0, 2)];
          default: w[k*W +: W] = 8'hFF;
        endcase
      end
      run_round(r, w, ($urandom_range(0, 3) == 0), 1'b0);
    end

    idle_start_zero();
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
